// File: rtl/guess_pkg.sv
// Shared sizes and types for the guessing-game input front-end.
package guess_pkg;

  localparam int NDIG                    = 4;
  localparam int DIGIT_W                 = 4;
  localparam int KEY_W                   = NDIG * DIGIT_W;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int DB_W_DEFAULT            = 18;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw input.
// rise/fall are registered one-cycle pulses on edges of the debounced level.
module btn_debounce #(
  parameter int CYCLES = 4,
  parameter int CNT_W  = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise,
  output logic fall
);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             stable_reg;
  logic             stable_next;
  logic             prev_reg;
  logic             rise_reg;
  logic             fall_reg;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreeing sample restarts the qualification window.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (sync2_reg != stable_reg) begin
      if (cnt_reg == CNT_W'(CYCLES - 1)) begin
        stable_next = ~stable_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      prev_reg   <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      sync1_reg  <= raw;
      sync2_reg  <= sync1_reg;
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      prev_reg   <= stable_reg;
      rise_reg   <= stable_reg & ~prev_reg;
      fall_reg   <= ~stable_reg & prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/guess_entry_capture.sv
// Debounced digit entry and commit front-end for the guessing game.
// Optional: define GUESS_COMMIT_COUNT_EN to add the saturating commit_count output.
module guess_entry_capture
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int DB_W            = DB_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NDIG-1:0]    btn,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               set_no,
  input  logic               clear,
  output logic [KEY_W-1:0]   digits,
  output logic [NDIG-1:0]    digit_mask,
  output logic               digit_stb,
  output logic [1:0]         digit_idx,
  output logic               commit_stb,
  output logic [KEY_W-1:0]   commit_value,
  output logic               reject_stb
`ifdef GUESS_COMMIT_COUNT_EN
  ,
  output logic [7:0]         commit_count
`endif
);

  logic [NDIG:0]        raw_vec;
  logic [NDIG:0]        rise_vec;
  logic [NDIG:0]        fall_vec;
  logic [DIGIT_W-1:0]   sw_meta_reg;
  logic [DIGIT_W-1:0]   sw_sync_reg;
  logic [NDIG-1:0]      press_vec;
  logic                 press_one;
  logic                 commit_req;
  digit_idx_t           press_idx;
  logic                 unused_edges;

  logic [KEY_W-1:0]     digits_reg, digits_next;
  logic [NDIG-1:0]      mask_reg, mask_next;
  digit_idx_t           idx_reg, idx_next;
  logic                 dstb_reg, dstb_next;
  logic                 cstb_reg, cstb_next;
  logic                 rstb_reg, rstb_next;
  logic [KEY_W-1:0]     cval_reg, cval_next;
`ifdef GUESS_COMMIT_COUNT_EN
  logic [7:0]           count_reg, count_next;
`endif

  // Top bit carries set_no; the rest are the digit buttons.
  assign raw_vec = {set_no, btn};

  generate
    for (genvar gi = 0; gi < NDIG + 1; gi++) begin : g_db
      btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES),
        .CNT_W  (DB_W)
      ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_vec[gi]),
        .rise  (rise_vec[gi]),
        .fall  (fall_vec[gi])
      );
    end
  endgenerate

  assign press_vec    = rise_vec[NDIG-1:0];
  assign commit_req   = fall_vec[NDIG];
  assign press_one    = $onehot(press_vec);
  // Button releases and set_no rising are deliberately ignored.
  assign unused_edges = ^{rise_vec[NDIG], fall_vec[NDIG-1:0]};

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (press_vec[i]) press_idx = digit_idx_t'(i);
    end
  end

  // Commit is judged on the old digits/mask before any same-cycle press lands.
  always_comb begin
    digits_next = digits_reg;
    mask_next   = mask_reg;
    idx_next    = idx_reg;
    cval_next   = cval_reg;
    dstb_next   = 1'b0;
    cstb_next   = 1'b0;
    rstb_next   = 1'b0;
`ifdef GUESS_COMMIT_COUNT_EN
    count_next  = count_reg;
`endif
    if (clear) begin
      digits_next = '0;
      mask_next   = '0;
`ifdef GUESS_COMMIT_COUNT_EN
      count_next  = '0;
`endif
    end else begin
      if (commit_req) begin
        if (mask_reg == '1) begin
          cstb_next = 1'b1;
          cval_next = digits_reg;
          mask_next = '0;
`ifdef GUESS_COMMIT_COUNT_EN
          if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
`endif
        end else begin
          rstb_next = 1'b1;
        end
      end
      if (press_one) begin
        digits_next[DIGIT_W*press_idx +: DIGIT_W] = sw_sync_reg;
        mask_next[press_idx] = 1'b1;
        dstb_next            = 1'b1;
        idx_next             = press_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      digits_reg  <= '0;
      mask_reg    <= '0;
      idx_reg     <= '0;
      dstb_reg    <= 1'b0;
      cstb_reg    <= 1'b0;
      rstb_reg    <= 1'b0;
      cval_reg    <= '0;
`ifdef GUESS_COMMIT_COUNT_EN
      count_reg   <= '0;
`endif
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
      digits_reg  <= digits_next;
      mask_reg    <= mask_next;
      idx_reg     <= idx_next;
      dstb_reg    <= dstb_next;
      cstb_reg    <= cstb_next;
      rstb_reg    <= rstb_next;
      cval_reg    <= cval_next;
`ifdef GUESS_COMMIT_COUNT_EN
      count_reg   <= count_next;
`endif
    end
  end

  assign digits       = digits_reg;
  assign digit_mask   = mask_reg;
  assign digit_idx    = idx_reg;
  assign digit_stb    = dstb_reg;
  assign commit_stb   = cstb_reg;
  assign commit_value = cval_reg;
  assign reject_stb   = rstb_reg;
`ifdef GUESS_COMMIT_COUNT_EN
  assign commit_count = count_reg;
`endif

endmodule

// File: tb/tb_guess_entry_capture.sv
// Bench for guess_entry_capture with a short debounce window and a history-based model.
module tb_guess_entry_capture;

  localparam int D    = 4;
  localparam int LAT  = D + 3;
  localparam int MAXE = 40000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  btn;
  logic [3:0]  sw;
  logic        set_no;
  logic        clear;
  logic [15:0] digits;
  logic [3:0]  digit_mask;
  logic        digit_stb;
  logic [1:0]  digit_idx;
  logic        commit_stb;
  logic [15:0] commit_value;
  logic        reject_stb;
`ifdef GUESS_COMMIT_COUNT_EN
  logic [7:0]  commit_count;
`endif

  guess_entry_capture #(.DEBOUNCE_CYCLES(D), .DB_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .sw           (sw),
    .set_no       (set_no),
    .clear        (clear),
    .digits       (digits),
    .digit_mask   (digit_mask),
    .digit_stb    (digit_stb),
    .digit_idx    (digit_idx),
    .commit_stb   (commit_stb),
    .commit_value (commit_value),
    .reject_stb   (reject_stb)
`ifdef GUESS_COMMIT_COUNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw-sample history per channel; a level is accepted once the
  // last D synchronised samples all disagree with it, and the event lands 2 edges later.
  bit   [4:0]  hist    [MAXE+8];
  logic [3:0]  swh     [MAXE+8];
  bit   [4:0]  rise_at [MAXE+8];
  bit   [4:0]  fall_at [MAXE+8];
  int          e, barrier;
  bit   [4:0]  mst;
  int          last_flip [5];
  logic [15:0] m_digits, m_cval;
  logic [3:0]  m_mask;
  logic [1:0]  m_didx;
  logic        m_dstb, m_cstb, m_rstb;
  logic [7:0]  m_cnt;

  int n_vec, n_bad;
  int step_no, first_d, obs_d, obs_c, obs_r;

  function automatic bit samp(int ch, int idx);
    if (idx <= barrier) return 1'b0;
    return hist[idx][ch];
  endfunction

  task automatic model_reset();
    barrier = e;
    for (int k = e + 1; k <= e + 4; k++) begin
      rise_at[k] = '0;
      fall_at[k] = '0;
    end
    mst = '0;
    for (int ch = 0; ch < 5; ch++) last_flip[ch] = e - 100;
    m_digits = '0; m_cval = '0; m_mask = '0; m_didx = '0;
    m_dstb = 1'b0; m_cstb = 1'b0; m_rstb = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge();
    bit [3:0]   presses;
    bit         creq, diff;
    logic [3:0] swv;
    int         idx;
    e++;
    hist[e] = {set_no, btn};
    swh[e]  = sw;
    for (int ch = 0; ch < 5; ch++) begin
      if (e - last_flip[ch] >= D) begin
        diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (samp(ch, e - 2 - j) == mst[ch]) diff = 1'b0;
        if (diff) begin
          mst[ch] = ~mst[ch];
          last_flip[ch] = e;
          if (mst[ch]) rise_at[e+2][ch] = 1'b1;
          else         fall_at[e+2][ch] = 1'b1;
        end
      end
    end
    presses = rise_at[e][3:0];
    creq    = fall_at[e][4];
    swv     = (e - 2 <= barrier) ? 4'h0 : swh[e-2];
    m_dstb = 1'b0; m_cstb = 1'b0; m_rstb = 1'b0;
    if (clear) begin
      m_digits = '0; m_mask = '0; m_cnt = '0;
    end else begin
      if (creq) begin
        if (m_mask == 4'hF) begin
          m_cstb = 1'b1; m_cval = m_digits; m_mask = '0;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else begin
          m_rstb = 1'b1;
        end
      end
      if ($countones(presses) == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (presses[i]) idx = i;
        m_digits[idx*4 +: 4] = swv;
        m_mask[idx] = 1'b1;
        m_dstb = 1'b1;
        m_didx = 2'(idx);
      end
    end
  endtask

  task automatic check(string nm);
    bit bad;
    bad = (digits !== m_digits) || (digit_mask !== m_mask) || (digit_stb !== m_dstb) ||
          (m_dstb && (digit_idx !== m_didx)) || (commit_stb !== m_cstb) ||
          (commit_value !== m_cval) || (reject_stb !== m_rstb);
`ifdef GUESS_COMMIT_COUNT_EN
    if (commit_count !== m_cnt) bad = 1'b1;
`endif
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s edge=%0d act dig=%h msk=%b dstb=%b idx=%0d cstb=%b cval=%h rstb=%b exp dig=%h msk=%b dstb=%b idx=%0d cstb=%b cval=%h rstb=%b",
               nm, e, digits, digit_mask, digit_stb, digit_idx, commit_stb, commit_value, reject_stb,
               m_digits, m_mask, m_dstb, m_didx, m_cstb, m_cval, m_rstb);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step(string nm);
    @(posedge clk);
    if (e >= MAXE) begin
      $display("FAIL cycle_budget edge=%0d limit=%0d", e, MAXE);
      $fatal(1);
    end
    model_edge();
    @(negedge clk);
    check(nm);
    step_no++;
    if (digit_stb) begin
      obs_d++;
      if (first_d < 0) first_d = step_no;
    end
    if (commit_stb) obs_c++;
    if (reject_stb) obs_r++;
  endtask

  task automatic clr_obs();
    obs_d = 0; obs_c = 0; obs_r = 0; first_d = -1;
  endtask

  task automatic press(int d, logic [3:0] val, string nm);
    btn = 4'(1 << d);
    sw  = val;
    repeat (10) step(nm);
    btn = 4'h0;
    repeat (10) step(nm);
  endtask

  task automatic set_pulse(string nm);
    set_no = 1'b1;
    repeat (10) step(nm);
    set_no = 1'b0;
    repeat (10) step(nm);
  endtask

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  sw;
    int          hold;
    logic [15:0] exp_digits;
    logic [3:0]  exp_mask;
    int          exp_stbs;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int base, r, hold;
    n_vec = 0; n_bad = 0; step_no = 0; e = 0; barrier = 0;
    rst_n = 1'b0; btn = '0; sw = '0; set_no = 1'b0; clear = 1'b0;
    model_reset();
    clr_obs();

    tbl[0] = '{4'b0001, 4'h7, 10, 16'h0007, 4'b0001, 1};
    tbl[1] = '{4'b0100, 4'h5,  3, 16'h0007, 4'b0001, 0};
    tbl[2] = '{4'b0011, 4'h9, 10, 16'h0007, 4'b0001, 0};
    tbl[3] = '{4'b1000, 4'h1, 10, 16'h1007, 4'b1001, 1};
    tbl[4] = '{4'b0100, 4'h2, 10, 16'h1207, 4'b1101, 1};
    tbl[5] = '{4'b0010, 4'h3, 10, 16'h1237, 4'b1111, 1};
    tbl[6] = '{4'b0001, 4'h4, 10, 16'h1234, 4'b1111, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_state");

    repeat (20) step("idle");
    chk("idle_no_strobes", obs_d + obs_c + obs_r, 0);

    for (int i = 0; i < 7; i++) begin
      clr_obs();
      base = step_no;
      btn = tbl[i].btn;
      sw  = tbl[i].sw;
      repeat (tbl[i].hold) step("tbl_hold");
      btn = 4'h0;
      repeat (12) step("tbl_rel");
      chk("tbl_digits", int'(digits), int'(tbl[i].exp_digits));
      chk("tbl_mask", int'(digit_mask), int'(tbl[i].exp_mask));
      chk("tbl_stb_count", obs_d, tbl[i].exp_stbs);
      if (tbl[i].exp_stbs == 1) chk("tbl_latency", first_d - base - 1, LAT);
    end

    clr_obs();
    set_pulse("commit");
    chk("commit_once", obs_c, 1);
    chk("commit_value", int'(commit_value), 16'h1234);
    chk("commit_mask", int'(digit_mask), 0);
    chk("commit_digits_kept", int'(digits), 16'h1234);

    press(0, 4'h5, "rej_press");
    press(1, 4'h6, "rej_press");
    clr_obs();
    set_pulse("reject");
    chk("reject_once", obs_r, 1);
    chk("reject_no_commit", obs_c, 0);
    chk("reject_mask", int'(digit_mask), 4'b0011);
    chk("reject_commit_value", int'(commit_value), 16'h1234);

    clr_obs();
    btn = 4'b0100; sw = 4'h9;
    repeat (LAT) step("clr_press");
    clear = 1'b1;
    step("clr_edge");
    clear = 1'b0;
    repeat (10) step("clr_hold");
    btn = 4'h0;
    repeat (10) step("clr_rel");
    chk("clear_no_stb", obs_d, 0);
    chk("clear_digits", int'(digits), 0);
    chk("clear_mask", int'(digit_mask), 0);

    btn = 4'b1000; sw = 4'hA;
    repeat (3) step("rstmid_pre");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rstmid_state");
    clr_obs();
    base = step_no;
    repeat (12) step("rstmid_post");
    chk("rstmid_latency", first_d - base - 1, LAT);
    chk("rstmid_digits", int'(digits), 16'hA000);
    btn = 4'h0;
    repeat (10) step("rstmid_rel");

    for (int s = 0; s < 300; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      btn = 4'h0;
      else if (r < 9) btn = 4'(1 << $urandom_range(0, 3));
      else            btn = 4'($urandom_range(0, 15));
      sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) set_no = ~set_no;
      hold = int'($urandom_range(1, 10));
      for (int h = 0; h < hold; h++) begin
        clear = ($urandom_range(0, 40) == 0);
        step("random");
      end
      clear = 1'b0;
    end

`ifdef GUESS_COMMIT_COUNT_EN
    btn = 4'h0; set_no = 1'b0; clear = 1'b1;
    step("cnt_clear");
    clear = 1'b0;
    repeat (12) step("cnt_settle");
    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < 4; d++) begin
        btn = 4'(1 << d);
        sw  = 4'(k + d);
        repeat (6) step("cnt_press");
        btn = 4'h0;
        repeat (6) step("cnt_rel");
      end
      set_no = 1'b1;
      repeat (8) step("cnt_set");
      set_no = 1'b0;
      repeat (8) step("cnt_set");
    end
    chk("commit_count_sat", int'(commit_count), 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
